ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//  Multi-cycle RV32M divide/remainder unit in the execute stage, downstream of the
//  decode control unit. Consumes the decoded ALU control code together with the
//  two operands and the destination register address. Computes the result with a
//  radix-2 restoring algorithm, one quotient bit per cycle.
//  Drives a busy flag that stalls the pipeline while a division is in progress.
// PARAMETERS
//  DATA_W   32   operand/result width; also the number of iteration cycles
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       reset, asynchronous, active-high
//  ex_start_i      in   1       request; sampled only in IDLE or DONE
//  ex_ALUctrl_i    in   5       op code; only `DIV/`DIVU/`REM/`REMU (define.v) accepted
//  ex_dividend_i   in   DATA_W  rs1 value, sampled on the accepting edge
//  ex_divisor_i    in   DATA_W  rs2 value, sampled on the accepting edge
//  ex_rd_addr_i    in   5       destination register, sampled on the accepting edge
//  ex_flush_i      in   1       abort any operation in flight (branch/trap flush)
//  div_busy_o      out  1       high while in CALC; pipeline stall request
//  div_valid_o     out  1       one-cycle pulse, result and rd valid
//  div_result_o    out  DATA_W  quotient or remainder; held until the next accept
//  div_rd_addr_o   out  5       rd of the completed op; held with the result
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, valid=0, result=0, rd_addr=0; all internal registers cleared.
//  FSM states: IDLE, CALC, DONE.
//   IDLE/DONE -> CALC on accept (start & legal op & !flush & not a special case).
//   IDLE/DONE -> DONE on accept of a special case (result is formed directly).
//   IDLE/DONE -> IDLE otherwise.
//   CALC -> CALC while the iteration counter != 0. CALC -> DONE after the DATA_W-th iteration.
//  flush: any state -> IDLE on the next edge; no valid pulse. Flush has priority over start.
//  start with a non-divide ALUctrl: ignored. start in CALC: ignored (busy is high).
//  valid=1 exactly in DONE. Back-to-back: a start in the DONE cycle is accepted.
//  Latency from the start cycle (cycle 0):
//   normal op: valid in cycle DATA_W+1.
//   special case: valid in cycle 1.
//  Signed ops (DIV, REM):
//   Divide the absolute values unsigned.
//   Quotient is negated iff the operand signs differ. Remainder takes the dividend's sign.
//  Unsigned ops (DIVU, REMU): operands are used as-is.
//  Iteration: {rem,quo} shift left 1; if rem >= |divisor| then rem -= |divisor| and quo[0]=1.
//  Special cases (RISC-V spec; no exception is raised):
//   divisor==0: DIV/DIVU -> all ones; REM/REMU -> dividend.
//   DIV -2^(W-1) / -1 -> -2^(W-1). REM of the same operands -> 0.
//  Reset asserted mid-CALC: everything returns to reset values immediately (asynchronous).
// TESTING
//  DIVU 100/7 -> result 14, valid in cycle 33, busy high cycles 1..32; REMU same -> 2.
//  DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIV 7/-2 -> 0xFFFFFFFD. REM 7/-2 -> 1.
//  DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5: valid in cycle 1, busy never high.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; valid in cycle 1.
//  flush in cycle 10 of CALC -> busy low and state IDLE next cycle; no valid pulse.
//   Then start DIVU 9/3 -> 3.
//  Back-to-back: a second start in the DONE cycle -> second valid exactly 33 cycles later.
//   rd_addr tracks each op.
//  rst pulsed mid-CALC -> all outputs 0 asynchronously; no valid after rst deasserts.

Source files
------------

// File: rtl/ex_div_if.sv
// ex_div_if: request/response bundle between the execute stage and the divider
// Signals (named from the divider's point of view):
//   i_start, i_alu_ctrl, i_dividend, i_divisor, i_rd_addr, i_flush  -> into the divider
//   o_busy, o_valid, o_result, o_rd_addr                            <- out of the divider
// Modports: master = pipeline side, slave = divider side.
interface ex_div_if #(
    parameter int DATA_W = 32
);
    logic              i_start;
    logic [4:0]        i_alu_ctrl;
    logic [DATA_W-1:0] i_dividend;
    logic [DATA_W-1:0] i_divisor;
    logic [4:0]        i_rd_addr;
    logic              i_flush;
    logic              o_busy;
    logic              o_valid;
    logic [DATA_W-1:0] o_result;
    logic [4:0]        o_rd_addr;

    modport master (
        output i_start, i_alu_ctrl, i_dividend, i_divisor, i_rd_addr, i_flush,
        input  o_busy, o_valid, o_result, o_rd_addr
    );

    modport slave (
        input  i_start, i_alu_ctrl, i_dividend, i_divisor, i_rd_addr, i_flush,
        output o_busy, o_valid, o_result, o_rd_addr
    );
endinterface

// File: rtl/ex_div.sv
// ex_div: multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per cycle
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   io_div  ex_div_if.slave: start/op/operands/rd/flush in; busy/valid/result/rd out
// busy is high in CALC (pipeline stall), valid pulses for the single DONE cycle.
// result and rd_addr are updated only on entry to DONE and held otherwise.
// Op codes are parameters so they can be bound to the decoder's encoding.
module ex_div #(
    parameter int         DATA_W  = 32,
    parameter logic [4:0] OP_DIV  = 5'd16,
    parameter logic [4:0] OP_DIVU = 5'd17,
    parameter logic [4:0] OP_REM  = 5'd18,
    parameter logic [4:0] OP_REMU = 5'd19
) (
    input logic    clk,
    input logic    rst,
    ex_div_if.slave io_div
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem, r_quo, r_dvsr, r_result;
    logic              r_neg_q, r_neg_r, r_is_rem;
    logic [4:0]        r_rd_pend, r_rd_addr;

    logic              w_is_div, w_is_rem, w_signed, w_rem_op, w_legal;
    logic              w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_accept;
    logic [DATA_W-1:0] w_abs_a, w_abs_b, w_special_res;
    logic [DATA_W:0]   w_rem_sh;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_nx, w_quo_nx, w_q_fin, w_r_fin;

    assign w_is_div = io_div.i_alu_ctrl == OP_DIV;
    assign w_is_rem = io_div.i_alu_ctrl == OP_REM;
    assign w_signed = w_is_div | w_is_rem;
    assign w_rem_op = w_is_rem | (io_div.i_alu_ctrl == OP_REMU);
    assign w_legal  = w_signed | w_rem_op | (io_div.i_alu_ctrl == OP_DIVU);

    assign w_a_neg = w_signed & io_div.i_dividend[DATA_W-1];
    assign w_b_neg = w_signed & io_div.i_divisor[DATA_W-1];
    assign w_abs_a = w_a_neg ? -io_div.i_dividend : io_div.i_dividend;
    assign w_abs_b = w_b_neg ? -io_div.i_divisor : io_div.i_divisor;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign w_div0    = io_div.i_divisor == '0;
    assign w_ovf     = w_signed & (io_div.i_dividend == {1'b1, {(DATA_W-1){1'b0}}}) & (&io_div.i_divisor);
    assign w_special = w_div0 | w_ovf;
    assign w_special_res = w_div0 ? (w_rem_op ? io_div.i_dividend : '1)
                                  : (w_rem_op ? '0 : io_div.i_dividend);

    assign w_accept = (r_state != CALC) & io_div.i_start & w_legal & ~io_div.i_flush;

    // One restoring step; the shifted remainder needs one extra bit before the compare,
    // but the difference always fits back in DATA_W bits.
    assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
    assign w_ge     = w_rem_sh >= {1'b0, r_dvsr};
    assign w_rem_nx = w_ge ? w_rem_sh[DATA_W-1:0] - r_dvsr : w_rem_sh[DATA_W-1:0];
    assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};
    assign w_q_fin  = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fin  = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = io_div.i_flush ? IDLE
               : w_accept ? (w_special ? DONE : CALC)
               : (r_state == CALC) ? ((r_cnt == '0) ? DONE : CALC)
               : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_rd_pend <= '0;
            r_result  <= '0;
            r_rd_addr <= '0;
        end else if (w_accept) begin
            r_cnt     <= CNT_W'(DATA_W-1);
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_dvsr    <= w_abs_b;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_is_rem  <= w_rem_op;
            r_rd_pend <= io_div.i_rd_addr;
            if (w_special) begin
                r_result  <= w_special_res;
                r_rd_addr <= io_div.i_rd_addr;
            end
        end else if (r_state == CALC && !io_div.i_flush) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_result  <= r_is_rem ? w_r_fin : w_q_fin;
                r_rd_addr <= r_rd_pend;
            end
        end
    end

    assign io_div.o_busy    = r_state == CALC;
    assign io_div.o_valid   = r_state == DONE;
    assign io_div.o_result  = r_result;
    assign io_div.o_rd_addr = r_rd_addr;
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div
module tb_ex_div;
    localparam int         W    = 32;
    localparam logic [4:0] DIV  = 5'd16;
    localparam logic [4:0] DIVU = 5'd17;
    localparam logic [4:0] REM  = 5'd18;
    localparam logic [4:0] REMU = 5'd19;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_div_if #(.DATA_W(W)) bus ();

    ex_div #(.DATA_W(W), .OP_DIV(DIV), .OP_DIVU(DIVU), .OP_REM(REM), .OP_REMU(REMU)) dut (
        .clk   (clk),
        .rst   (rst),
        .io_div(bus)
    );

    // Issues one op in the current cycle (cycle 0) and returns at the cycle valid is seen.
    // lat = cycle index of valid (0 on timeout), busy_n = cycles with busy high.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rd_o,
                         output int lat, output int busy_n);
        bus.i_alu_ctrl = op;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_rd_addr  = rd;
        bus.i_start    = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        lat    = 0;
        busy_n = 0;
        res    = '0;
        rd_o   = '0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (bus.o_busy) busy_n++;
            if (bus.o_valid) begin
                lat  = k;
                res  = bus.o_result;
                rd_o = bus.o_rd_addr;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_alu_ctrl = '0;
        bus.i_dividend = '0;
        bus.i_divisor = '0;
        bus.i_rd_addr = '0;
        #2;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.o_result); end
        checks++; if (bus.o_rd_addr !== 5'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", bus.o_rd_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_divu;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bn;
        do_op(DIVU, 32'd100, 32'd7, 5'd3, res, rdo, lat, bn);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_result: got %h expected %h", res, 32'd14); end
        checks++; if (rdo !== 5'd3) begin errors++; $display("FAIL divu_rd: got %0d expected 3", rdo); end
        checks++; if (lat != 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
        checks++; if (bn != 32) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 32", bn); end
        @(posedge clk); #1;
        do_op(REMU, 32'd100, 32'd7, 5'd4, res, rdo, lat, bn);
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_result: got %h expected 2", res); end
        checks++; if (lat != 33) begin errors++; $display("FAIL remu_latency: got %0d expected 33", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed;
        logic [4:0]  ops[4] = '{DIV, REM, DIV, REM};
        logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] ex[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bn;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 5'(i + 10), res, rdo, lat, bn);
            checks++; if (res !== ex[i]) begin errors++; $display("FAIL signed_%0d_result: got %h expected %h", i, res, ex[i]); end
            checks++; if (lat != 33) begin errors++; $display("FAIL signed_%0d_latency: got %0d expected 33", i, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_special;
        logic [4:0]  ops[6] = '{DIV, REMU, DIVU, REM, DIV, REM};
        logic [31:0] as[6]  = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[6]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex[6]  = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bn;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], 5'(i + 20), res, rdo, lat, bn);
            checks++; if (res !== ex[i]) begin errors++; $display("FAIL special_%0d_result: got %h expected %h", i, res, ex[i]); end
            checks++; if (rdo !== 5'(i + 20)) begin errors++; $display("FAIL special_%0d_rd: got %0d expected %0d", i, rdo, i + 20); end
            checks++; if (lat != 1) begin errors++; $display("FAIL special_%0d_latency: got %0d expected 1", i, lat); end
            checks++; if (bn != 0) begin errors++; $display("FAIL special_%0d_busy: got %0d cycles expected 0", i, bn); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal;
        int seen = 0;
        bus.i_alu_ctrl = 5'd0;
        bus.i_dividend = 32'd100;
        bus.i_divisor  = 32'd7;
        bus.i_start    = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.o_busy || bus.o_valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL illegal_op_ignored: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_flush;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bn;
        int          seen = 0;
        bus.i_alu_ctrl = DIVU;
        bus.i_dividend = 32'hFFFF_FFFF;
        bus.i_divisor  = 32'd3;
        bus.i_rd_addr  = 5'd1;
        bus.i_start    = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b expected 1", bus.o_busy); end
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.o_busy); end
        for (int k = 0; k < 40; k++) begin
            if (bus.o_valid || bus.o_busy) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_valid: got %0d active cycles expected 0", seen); end
        // flush wins over a simultaneous legal start
        bus.i_alu_ctrl = DIVU;
        bus.i_dividend = 32'd9;
        bus.i_divisor  = 32'd3;
        bus.i_start    = 1'b1;
        bus.i_flush    = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        checks++; if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL flush_priority: got busy=%b valid=%b expected 0 0", bus.o_busy, bus.o_valid); end
        do_op(DIVU, 32'd9, 32'd3, 5'd2, res, rdo, lat, bn);
        checks++; if (res !== 32'd3) begin errors++; $display("FAIL post_flush_result: got %h expected 3", res); end
        checks++; if (lat != 33) begin errors++; $display("FAIL post_flush_latency: got %0d expected 33", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bn;
        do_op(DIVU, 32'd100, 32'd7, 5'd5, res, rdo, lat, bn);
        checks++; if (res !== 32'd14 || rdo !== 5'd5) begin errors++; $display("FAIL b2b_first: got %h rd %0d expected 0000000e rd 5", res, rdo); end
        // do_op returns in the DONE cycle, so this start lands in DONE
        do_op(REMU, 32'd100, 32'd7, 5'd9, res, rdo, lat, bn);
        checks++; if (res !== 32'd2 || rdo !== 5'd9) begin errors++; $display("FAIL b2b_second: got %h rd %0d expected 00000002 rd 9", res, rdo); end
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bn;
        int          seen = 0;
        bus.i_alu_ctrl = DIVU;
        bus.i_dividend = 32'd100;
        bus.i_divisor  = 32'd7;
        bus.i_rd_addr  = 5'd7;
        bus.i_start    = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
        end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy: got %b expected 1", bus.o_busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL arst_flags: got busy=%b valid=%b expected 0 0", bus.o_busy, bus.o_valid); end
        checks++; if (bus.o_result !== 32'h0 || bus.o_rd_addr !== 5'h0) begin errors++; $display("FAIL arst_data: got %h rd %0d expected 0 rd 0", bus.o_result, bus.o_rd_addr); end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 40; k++) begin
            if (bus.o_valid || bus.o_busy) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL arst_no_valid: got %0d active cycles expected 0", seen); end
        do_op(DIVU, 32'd9, 32'd3, 5'd6, res, rdo, lat, bn);
        checks++; if (res !== 32'd3 || lat != 33) begin errors++; $display("FAIL post_arst_op: got %h lat %0d expected 00000003 lat 33", res, lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_special();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
